proc_test_sequencer: RTL and testbench

Synthesizable run controller for the in-order single-issue core's bring-up harness. It streams a program image into instruction memory, holds the core in reset for a programmable interval, releases it, and watches the data-memory write bus for a tohost termination write. It flags PASS, FAIL, TIMEOUT or HANG. It sits beside `proc_top`, drives the core's `resetn` and the imem write port, and replaces hand-poked `mem_array` preloads and fixed `$finish` delays.

---
 rtl/proc_tb_pkg.sv | 27 ++
 rtl/proc_test_sequencer_if.sv | 21 ++
 rtl/tseq_cycle_ctr.sv | 31 +++
 rtl/proc_test_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_proc_test_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_tb_pkg.sv
// proc_test_sequencer shared types: FSM states, run status codes
// and the default tohost termination address.
package proc_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE
  } tseq_state_e;

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_FAIL    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_HANG    = 2'd3
  } status_e;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;

  // tohost value 1 means pass; anything else carries a fail code
  function automatic status_e tohost_status(input logic is_one);
    return is_one ? ST_PASS : ST_FAIL;
  endfunction

endpackage

// File: rtl/proc_test_sequencer_if.sv
// proc_test_sequencer program-image load stream.
// master = image source, slave = sequencer.
interface proc_test_sequencer_if #(
  parameter int XLEN = 32
);
  logic            load_valid;
  logic            load_ready;
  logic [XLEN-1:0] load_addr;
  logic [31:0]     load_data;
  logic            load_last;

  modport master (
    output load_valid, load_addr, load_data, load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_addr, load_data, load_last,
    output load_ready
  );
endinterface

// File: rtl/tseq_cycle_ctr.sv
// tseq_cycle_ctr: loadable saturating counter, up or down.
// Down counts stop at zero, up counts stop at all-ones.
module tseq_cycle_ctr #(
  parameter int W    = 8,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count
);
  localparam logic [W-1:0] LIM = DOWN ? '0 : '1;

  logic [W-1:0] r_count;

  // load has priority over counting; hold at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != LIM)) begin
      if (DOWN) r_count <= r_count - W'(1);
      else      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/proc_test_sequencer.sv
// proc_test_sequencer: load imem, hold core reset, run, watch tohost.
// Optional hang detector: define PROC_TSEQ_HANG_DETECT_EN.
module proc_test_sequencer
  import proc_tb_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              IMEM_DEPTH  = 256,
  localparam int             IMEM_AW     = $clog2(IMEM_DEPTH),
  parameter int              RST_CYCLES  = 4,
  parameter int              MAX_CYCLES  = 1000,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEF),
  parameter int              HANG_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  proc_test_sequencer_if.slave  ld,
  output logic                  imem_we,
  output logic [IMEM_AW-1:0]    imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  core_resetn,
  input  logic                  dmem_we,
  input  logic [XLEN-1:0]       dmem_addr,
  input  logic [XLEN-1:0]       dmem_wdata,
  input  logic [XLEN-1:0]       core_pc,
  output logic                  busy,
  output logic                  done,
  output status_e               status,
  output logic [XLEN-2:0]       fail_code,
  output logic [31:0]           cycle_count,
  output logic                  load_err
);
  localparam int HOLD_W = $clog2(RST_CYCLES + 1);

  tseq_state_e          r_state;
  logic                 r_load_ready;
  logic                 r_imem_we;
  logic [IMEM_AW-1:0]   r_imem_waddr;
  logic [31:0]          r_imem_wdata;
  logic                 r_core_resetn;
  logic                 r_busy;
  logic                 r_done;
  status_e              r_status;
  logic [XLEN-2:0]      r_fail_code;
  logic                 r_load_err;

  logic                 w_in_hold;
  logic                 w_in_run;
  logic                 w_start_ok;
  logic                 w_beat;
  logic                 w_in_range;
  logic                 w_enter_hold;
  logic                 w_hold_end;
  logic                 w_tohost;
  logic                 w_pass;
  logic                 w_timeout;
  logic                 w_hang;
  logic                 w_term;
  logic [HOLD_W-1:0]    w_hold_cnt;
  logic [31:0]          w_cyc;
  logic [32:0]          w_cyc_inc;

  // decode handshakes and termination conditions
  always_comb begin
    w_in_hold    = (r_state == S_HOLD);
    w_in_run     = (r_state == S_RUN);
    w_start_ok   = start &&
                   ((r_state == S_IDLE) || (r_state == S_DONE));
    w_beat       = (r_state == S_LOAD) && ld.load_valid;
    w_in_range   = ld.load_addr < XLEN'(IMEM_DEPTH);
    w_enter_hold = w_beat && ld.load_last;
    w_hold_end   = w_in_hold && (w_hold_cnt == HOLD_W'(1));
    w_tohost     = w_in_run && dmem_we &&
                   (dmem_addr == TOHOST_ADDR);
    w_pass       = (dmem_wdata == XLEN'(1));
    w_cyc_inc    = {1'b0, w_cyc} + 33'd1;
    w_timeout    = w_in_run && (w_cyc_inc >= 33'(MAX_CYCLES));
    w_term       = w_tohost || w_hang || w_timeout;
  end

  tseq_cycle_ctr #(
    .W    (HOLD_W),
    .DOWN (1'b1)
  ) u_hold_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_enter_hold),
    .i_load_val (HOLD_W'(RST_CYCLES)),
    .i_en       (w_in_hold),
    .o_count    (w_hold_cnt)
  );

  tseq_cycle_ctr #(
    .W    (32),
    .DOWN (1'b0)
  ) u_run_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start_ok),
    .i_load_val (32'd0),
    .i_en       (w_in_run),
    .o_count    (w_cyc)
  );

`ifdef PROC_TSEQ_HANG_DETECT_EN
  localparam int HANG_W = $clog2(HANG_CYCLES + 1);

  logic [XLEN-1:0]  r_last_pc;
  logic             r_pc_vld;
  logic             w_same_pc;
  logic [HANG_W-1:0] w_hang_cnt;
  logic [HANG_W:0]  w_hang_inc;

  // previous-cycle PC, valid only from the second RUN cycle on
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_pc <= '0;
      r_pc_vld  <= 1'b0;
    end else begin
      r_last_pc <= core_pc;
      r_pc_vld  <= w_in_run;
    end
  end

  assign w_same_pc  = r_pc_vld && (core_pc == r_last_pc);
  assign w_hang_inc = {1'b0, w_hang_cnt} + (HANG_W + 1)'(1);
  assign w_hang     = w_in_run && w_same_pc &&
                      (w_hang_inc >= (HANG_W + 1)'(HANG_CYCLES));

  tseq_cycle_ctr #(
    .W    (HANG_W),
    .DOWN (1'b0)
  ) u_hang_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (!w_same_pc),
    .i_load_val (HANG_W'(1)),
    .i_en       (w_same_pc),
    .o_count    (w_hang_cnt)
  );
`else
  logic w_unused_pc;

  assign w_unused_pc = ^core_pc;
  assign w_hang      = 1'b0;
`endif

  // sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_load_ready  <= 1'b0;
      r_imem_we     <= 1'b0;
      r_imem_waddr  <= '0;
      r_imem_wdata  <= '0;
      r_core_resetn <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_status      <= ST_PASS;
      r_fail_code   <= '0;
      r_load_err    <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state      <= S_LOAD;
            r_load_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_status     <= ST_PASS;
            r_fail_code  <= '0;
            r_load_err   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            r_imem_we    <= w_in_range;
            r_imem_waddr <= ld.load_addr[IMEM_AW-1:0];
            r_imem_wdata <= ld.load_data;
            if (!w_in_range) r_load_err <= 1'b1;
            if (ld.load_last) begin
              r_state      <= S_HOLD;
              r_load_ready <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (w_hold_end) begin
            r_state       <= S_RUN;
            r_core_resetn <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_term) begin
            r_state       <= S_DONE;
            r_core_resetn <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            if (w_tohost) begin
              r_status <= tohost_status(w_pass);
              if (!w_pass) r_fail_code <= dmem_wdata[XLEN-1:1];
            end else if (w_hang) begin
              r_status <= ST_HANG;
            end else begin
              r_status <= ST_TIMEOUT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld.load_ready = r_load_ready;
  assign imem_we       = r_imem_we;
  assign imem_waddr    = r_imem_waddr;
  assign imem_wdata    = r_imem_wdata;
  assign core_resetn   = r_core_resetn;
  assign busy          = r_busy;
  assign done          = r_done;
  assign status        = r_status;
  assign fail_code     = r_fail_code;
  assign cycle_count   = w_cyc;
  assign load_err      = r_load_err;
endmodule

// File: tb/tb_proc_test_sequencer.sv
// tb_proc_test_sequencer: directed vectors for proc_test_sequencer.
// Hang cases build only with PROC_TSEQ_HANG_DETECT_EN.
module tb_proc_test_sequencer;
  import proc_tb_pkg::*;

  localparam int RSTC = 4;
  localparam int MAXC = 50;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
    bit          exp_we;
  } beat_t;

  typedef struct {
    int          at;
    logic [31:0] addr;
    logic [31:0] data;
    status_e     st;
    logic [30:0] fc;
  } term_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_resetn;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] core_pc;
  logic        busy;
  logic        done;
  status_e     status;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;
  logic        load_err;

  bit          pc_run;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] tb_mem [256];
  beat_t       beats[$];
  term_t       terms[4];

  logic [31:0] pw [9] = '{
    32'h0010_0093, 32'h0020_0113, 32'h0000_8193,
    32'h0001_0093, 32'h0001_8113, 32'h0000_12b7,
    32'h0010_0313, 32'h0062_a023, 32'h0000_006f
  };

  proc_test_sequencer_if #(.XLEN(32)) ld_if ();

  proc_test_sequencer #(
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ld          (ld_if),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .core_resetn (core_resetn),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .core_pc     (core_pc),
    .busy        (busy),
    .done        (done),
    .status      (status),
    .fail_code   (fail_code),
    .cycle_count (cycle_count),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  // stand-in instruction memory fed by the write port
  always @(posedge clk) begin
    if (imem_we) tb_mem[imem_waddr] <= imem_wdata;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (pc_run) core_pc = core_pc + 32'd4;
  endtask

  task automatic chk_reset_vals();
    chk("rst_load_ready", 64'(ld_if.load_ready), 64'(0));
    chk("rst_imem_we", 64'(imem_we), 64'(0));
    chk("rst_imem_waddr", 64'(imem_waddr), 64'(0));
    chk("rst_imem_wdata", 64'(imem_wdata), 64'(0));
    chk("rst_core_resetn", 64'(core_resetn), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_status", 64'(status), 64'(0));
    chk("rst_fail_code", 64'(fail_code), 64'(0));
    chk("rst_cycle_count", 64'(cycle_count), 64'(0));
    chk("rst_load_err", 64'(load_err), 64'(0));
  endtask

  task automatic set_prog();
    beats.delete();
    for (int i = 0; i < 9; i++)
      beats.push_back('{32'(i), pw[i], (i == 8), 1'b1});
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_done", 64'(done), 64'(0));
    chk("start_status", 64'(status), 64'(ST_PASS));
    chk("start_fail_code", 64'(fail_code), 64'(0));
    chk("start_cycle_count", 64'(cycle_count), 64'(0));
    chk("start_load_err", 64'(load_err), 64'(0));
  endtask

  // stream beats, then watch the reset-hold window
  task automatic load_and_hold();
    for (int i = 0; i < beats.size(); i++) begin
      chk("load_ready", 64'(ld_if.load_ready), 64'(1));
      ld_if.load_valid = 1'b1;
      ld_if.load_addr  = beats[i].addr;
      ld_if.load_data  = beats[i].data;
      ld_if.load_last  = beats[i].last;
      tick();
      chk("imem_we", 64'(imem_we), 64'(beats[i].exp_we));
      if (beats[i].exp_we) begin
        chk("imem_waddr", 64'(imem_waddr), 64'(beats[i].addr[7:0]));
        chk("imem_wdata", 64'(imem_wdata), 64'(beats[i].data));
      end
    end
    ld_if.load_valid = 1'b0;
    ld_if.load_last  = 1'b0;
    chk("hold_load_ready", 64'(ld_if.load_ready), 64'(0));
    for (int k = 0; k < RSTC; k++) begin
      chk("core_resetn_hold", 64'(core_resetn), 64'(0));
      tick();
    end
    chk("core_resetn_run", 64'(core_resetn), 64'(1));
    for (int i = 0; i < beats.size(); i++) begin
      if (beats[i].exp_we)
        chk("imem_word", 64'(tb_mem[beats[i].addr[7:0]]),
            64'(beats[i].data));
    end
  endtask

  // runs from RUN cycle 1; stores tohost at RUN cycle 'at'
  task automatic run_term(input term_t t);
    for (int k = 1; k < t.at; k++) begin
      if (k == 1) begin
        dmem_we    = 1'b1;
        dmem_addr  = 32'h0000_1004;
        dmem_wdata = 32'd1;
      end
      tick();
      dmem_we = 1'b0;
    end
    chk("pre_done", 64'(done), 64'(0));
    chk("pre_cycle_count", 64'(cycle_count), 64'(t.at - 1));
    dmem_we    = 1'b1;
    dmem_addr  = t.addr;
    dmem_wdata = t.data;
    tick();
    dmem_we = 1'b0;
    chk("term_done", 64'(done), 64'(1));
    chk("term_status", 64'(status), 64'(t.st));
    chk("term_fail_code", 64'(fail_code), 64'(t.fc));
    chk("term_cycle_count", 64'(cycle_count), 64'(t.at));
    chk("term_core_resetn", 64'(core_resetn), 64'(0));
    chk("term_busy", 64'(busy), 64'(0));
  endtask

  task automatic wait_done(input string nm, input int exp_k);
    int k;
    k = 1;
    while (done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk(nm, 64'(k), 64'(exp_k));
  endtask

  initial begin
    terms[0] = '{3, 32'h0000_1000, 32'd1, ST_PASS, 31'd0};
    terms[1] = '{5, 32'h0000_1000, 32'd7, ST_FAIL, 31'd3};
    terms[2] = '{1, 32'h0000_1000, 32'hFFFF_FFFE, ST_FAIL,
                 31'h7FFF_FFFF};
    terms[3] = '{2, 32'h0000_1000, 32'd0, ST_FAIL, 31'd0};

    reset            = 1'b1;
    start            = 1'b0;
    ld_if.load_valid = 1'b0;
    ld_if.load_addr  = '0;
    ld_if.load_data  = '0;
    ld_if.load_last  = 1'b0;
    dmem_we          = 1'b0;
    dmem_addr        = '0;
    dmem_wdata       = '0;
    core_pc          = '0;
    pc_run           = 1'b1;
    tick();
    tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      set_prog();
      do_start();
      load_and_hold();
      run_term(terms[i]);
      tick();
    end

    set_prog();
    do_start();
    load_and_hold();
    wait_done("timeout_done_cycle", MAXC + 1);
    chk("timeout_status", 64'(status), 64'(ST_TIMEOUT));
    chk("timeout_cycle_count", 64'(cycle_count), 64'(MAXC));
    tick();

    beats.delete();
    beats.push_back('{32'd0, 32'hAAAA_0001, 1'b0, 1'b1});
    beats.push_back('{32'd300, 32'hBBBB_0002, 1'b0, 1'b0});
    beats.push_back('{32'd1, 32'hCCCC_0003, 1'b1, 1'b1});
    do_start();
    load_and_hold();
    chk("load_err_set", 64'(load_err), 64'(1));
    run_term('{2, 32'h0000_1000, 32'd1, ST_PASS, 31'd0});
    chk("load_err_sticky", 64'(load_err), 64'(1));
    tick();

    set_prog();
    do_start();
    load_and_hold();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_start_ign_ready", 64'(ld_if.load_ready), 64'(0));
    chk("run_start_ign_resetn", 64'(core_resetn), 64'(1));
    chk("run_start_ign_busy", 64'(busy), 64'(1));
    tick();
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();
    set_prog();
    do_start();
    load_and_hold();
    run_term('{4, 32'h0000_1000, 32'd1, ST_PASS, 31'd0});
    tick();

`ifdef PROC_TSEQ_HANG_DETECT_EN
    pc_run  = 1'b0;
    core_pc = 32'h0000_0020;
    set_prog();
    do_start();
    load_and_hold();
    wait_done("hang_done_cycle", 17);
    chk("hang_status", 64'(status), 64'(ST_HANG));
    chk("hang_cycle_count", 64'(cycle_count), 64'(16));
    tick();
    set_prog();
    do_start();
    load_and_hold();
    run_term('{16, 32'h0000_1000, 32'd1, ST_PASS, 31'd0});
    pc_run = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
